// File: rtl/shift_reg_ctrl.sv
// Control FSM for a feedback delay line used by a radix-2 single-path delay
// feedback stage. Sequences fill, butterfly, drain and flush phases over
// half-frames of DELAY_LENGTH blocks and flags delay-line protocol misuse.
module shift_reg_ctrl #(
  parameter int unsigned DELAY_LENGTH = 16,
  localparam int unsigned IdxW = (DELAY_LENGTH > 1) ? $clog2(DELAY_LENGTH) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            din_valid,
  input  logic            flush,
  input  logic            sr_full,
  input  logic            sr_empty,
  output logic            sr_write,
  output logic            sr_read,
  output logic            fb_sel,
  output logic            out_valid,
  output logic            out_sel,
  output logic [IdxW-1:0] blk_idx,
  output logic            busy,
  output logic            err
);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StBfly,
    StDrain,
    StFlush
  } state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(DELAY_LENGTH - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] idx_inc;
  logic            is_last;
  logic            out_valid_q, out_sel_q, out_sel_d;
  logic            busy_q, err_q, err_d;
  logic            wr_raw, rd_raw;

  assign is_last = (idx_q == LastIdx);
  assign idx_inc = is_last ? '0 : idx_q + IdxW'(1);

  // Next-state, block index and raw delay-line strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_raw  = 1'b0;
    rd_raw  = 1'b0;
    fb_sel  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // flush is deliberately ignored: nothing is stored yet.
        if (din_valid) begin
          wr_raw = 1'b1;
          if (DELAY_LENGTH == 1) begin
            state_d = StBfly;
            idx_d   = '0;
          end else begin
            state_d = StFill;
            idx_d   = IdxW'(1);
          end
        end
      end
      StFill: begin
        if (din_valid) begin
          wr_raw = 1'b1;
          idx_d  = idx_inc;
          if (is_last) state_d = StBfly;
        end
      end
      StBfly: begin
        if (din_valid) begin
          rd_raw = 1'b1;
          wr_raw = 1'b1;
          fb_sel = 1'b1;
          idx_d  = idx_inc;
          if (is_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (din_valid) begin
          // Emit stored difference while refilling with the next half-frame.
          rd_raw = 1'b1;
          wr_raw = 1'b1;
          idx_d  = idx_inc;
          if (is_last) state_d = StBfly;
        end else if (flush) begin
          rd_raw  = 1'b1;
          idx_d   = idx_inc;
          state_d = is_last ? StIdle : StFlush;
        end
      end
      StFlush: begin
        // Reads continue unconditionally; incoming blocks are dropped.
        rd_raw = 1'b1;
        idx_d  = idx_inc;
        if (is_last) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Strobes are suppressed while reset is asserted.
  always_comb begin
    sr_write  = wr_raw & rstn;
    sr_read   = rd_raw & rstn;
    out_sel_d = sr_read & (state_q != StBfly);
    err_d     = err_q
              | (sr_write & ~sr_read & sr_full)
              | (sr_read & sr_empty)
              | (din_valid & (state_q == StFlush));
  end

  // State and registered status; busy tracks the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= sr_read;
      out_sel_q   <= out_sel_d;
      busy_q      <= (state_d != StIdle);
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign blk_idx   = idx_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with DELAY_LENGTH=16.
module tb_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       din_valid, flush, sr_full, sr_empty;
  logic       sr_write, sr_read, fb_sel, out_valid, out_sel, busy, err;
  logic [3:0] blk_idx;

  int passed = 0;
  int total  = 0;

  shift_reg_ctrl #(.DELAY_LENGTH(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din_valid (din_valid),
    .flush     (flush),
    .sr_full   (sr_full),
    .sr_empty  (sr_empty),
    .sr_write  (sr_write),
    .sr_read   (sr_read),
    .fb_sel    (fb_sel),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .blk_idx   (blk_idx),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; din_valid = 1'b0; flush = 1'b0; sr_full = 1'b0; sr_empty = 1'b0;
    tick(); tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  // Unchecked stimulus: n consecutive input blocks.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1; flush = 1'b0;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; din_valid = 1'b1; flush = 1'b1; sr_full = 1'b1; sr_empty = 1'b1;
    #3;
    total++;
    if ({sr_write, sr_read, out_valid, out_sel, busy, err} !== 6'b0 || blk_idx !== 4'd0)
      $display("FAIL reset_outputs: got wr=%b rd=%b ov=%b os=%b busy=%b err=%b idx=%0d, need all 0",
               sr_write, sr_read, out_valid, out_sel, busy, err, blk_idx);
    else passed++;
    do_reset();
  endtask

  task automatic test_fill_to_bfly();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1;
      #1;
      total++;
      if ({sr_write, sr_read, fb_sel} !== 3'b100)
        $display("FAIL fill_strobes[%0d]: got wr/rd/fb=%b%b%b need 100", i, sr_write, sr_read,
                 fb_sel);
      else passed++;
      tick();
    end
    din_valid = 1'b0;
    total++;
    if (blk_idx !== 4'd0 || busy !== 1'b1)
      $display("FAIL fill_end: got idx=%0d busy=%b need idx=0 busy=1", blk_idx, busy);
    else passed++;
    // BFLY phase
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1;
      #1;
      total++;
      if ({sr_write, sr_read, fb_sel} !== 3'b111)
        $display("FAIL bfly_strobes[%0d]: got wr/rd/fb=%b%b%b need 111", i, sr_write, sr_read,
                 fb_sel);
      else passed++;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 1'b0)
        $display("FAIL bfly_out[%0d]: got ov=%b os=%b need ov=1 os=0", i, out_valid, out_sel);
      else passed++;
    end
    // Now in DRAIN at idx 0; an idle cycle must hold.
    din_valid = 1'b0; flush = 1'b0;
    #1;
    total++;
    if (sr_read !== 1'b0 || sr_write !== 1'b0)
      $display("FAIL drain_hold_strobes: got rd=%b wr=%b need 0 0", sr_read, sr_write);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || blk_idx !== 4'd0 || busy !== 1'b1 || err !== 1'b0)
      $display("FAIL drain_hold: got ov=%b idx=%0d busy=%b err=%b need 0 0 1 0", out_valid,
               blk_idx, busy, err);
    else passed++;
  endtask

  task automatic test_fill_gaps();
    logic [3:0] pat;
    logic [3:0] exp_idx;
    int         writes;
    pat = 4'b1001; // applied MSB first: 1,0,0,1
    do_reset();
    feed(1); // IDLE -> FILL, idx 1
    exp_idx = 4'd1;
    writes  = 0;
    for (int i = 3; i >= 0; i--) begin
      din_valid = pat[i];
      #1;
      if (sr_write) writes++;
      tick();
      if (pat[i]) exp_idx = exp_idx + 4'd1;
      total++;
      if (blk_idx !== exp_idx)
        $display("FAIL gap_idx[%0d]: got %0d need %0d", 3 - i, blk_idx, exp_idx);
      else passed++;
    end
    din_valid = 1'b0;
    total++;
    if (writes != 2) $display("FAIL gap_writes: got %0d need 2", writes);
    else passed++;
  endtask

  task automatic test_drain_to_bfly();
    do_reset();
    feed(32);
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1;
      #1;
      total++;
      if ({sr_write, sr_read, fb_sel} !== 3'b110)
        $display("FAIL drain_strobes[%0d]: got wr/rd/fb=%b%b%b need 110", i, sr_write,
                 sr_read, fb_sel);
      else passed++;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 1'b1)
        $display("FAIL drain_out[%0d]: got ov=%b os=%b need 1 1", i, out_valid, out_sel);
      else passed++;
    end
    #1;
    total++;
    if (fb_sel !== 1'b1 || sr_read !== 1'b1)
      $display("FAIL back_to_bfly: got fb=%b rd=%b need 1 1", fb_sel, sr_read);
    else passed++;
    tick();
    total++;
    if (out_sel !== 1'b0) $display("FAIL back_to_bfly_sel: got %b need 0", out_sel);
    else passed++;
    din_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    feed(32);
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b0; flush = (i == 0);
      #1;
      total++;
      if (sr_read !== 1'b1 || sr_write !== 1'b0)
        $display("FAIL flush_strobes[%0d]: got rd=%b wr=%b need 1 0", i, sr_read, sr_write);
      else passed++;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 1'b1)
        $display("FAIL flush_out[%0d]: got ov=%b os=%b need 1 1", i, out_valid, out_sel);
      else passed++;
    end
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || blk_idx !== 4'd0 || err !== 1'b0)
      $display("FAIL flush_end: got busy=%b idx=%0d err=%b need 0 0 0", busy, blk_idx, err);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_idle_ov: got %b need 0", out_valid);
    else passed++;
  endtask

  task automatic test_flush_din_err();
    do_reset();
    feed(32);
    flush = 1'b1;
    tick(); // DRAIN -> FLUSH, idx 1
    flush = 1'b0; din_valid = 1'b1;
    #1;
    total++;
    if (sr_write !== 1'b0 || sr_read !== 1'b1)
      $display("FAIL flush_drop: got wr=%b rd=%b need 0 1", sr_write, sr_read);
    else passed++;
    tick();
    din_valid = 1'b0;
    total++;
    if (err !== 1'b1 || blk_idx !== 4'd2)
      $display("FAIL flush_err: got err=%b idx=%0d need 1 2", err, blk_idx);
    else passed++;
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL err_sticky: got err=%b busy=%b need 1 0", err, busy);
    else passed++;
  endtask

  task automatic test_full_err();
    do_reset();
    feed(2);
    total++;
    if (err !== 1'b0) $display("FAIL full_pre: got err=%b need 0", err);
    else passed++;
    sr_full = 1'b1; din_valid = 1'b1;
    tick();
    sr_full = 1'b0; din_valid = 1'b0;
    total++;
    if (err !== 1'b1) $display("FAIL full_err: got err=%b need 1", err);
    else passed++;
  endtask

  task automatic test_reset_mid_bfly();
    do_reset();
    feed(19);
    din_valid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({sr_write, sr_read, out_valid, out_sel, busy, err} !== 6'b0 || blk_idx !== 4'd0)
      $display("FAIL mid_reset: got wr=%b rd=%b ov=%b os=%b busy=%b err=%b idx=%0d, need 0",
               sr_write, sr_read, out_valid, out_sel, busy, err, blk_idx);
    else passed++;
    #2;
    rstn = 1'b1;
    #1;
    total++;
    if ({sr_write, sr_read, fb_sel} !== 3'b100)
      $display("FAIL post_reset_idle: got wr/rd/fb=%b%b%b need 100", sr_write, sr_read, fb_sel);
    else passed++;
    tick();
    din_valid = 1'b0;
    total++;
    if (blk_idx !== 4'd1 || busy !== 1'b1)
      $display("FAIL post_reset_fill: got idx=%0d busy=%b need 1 1", blk_idx, busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_to_bfly();
    test_fill_gaps();
    test_drain_to_bfly();
    test_flush();
    test_flush_din_err();
    test_full_err();
    test_reset_mid_bfly();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
